// File: rtl/interconnect_pkg.sv
// ----------------------------------------------------------------------------
// interconnect_pkg
// Shared definitions for the master/slave interconnect.
//   - arb_state_t      : per-slave arbiter state (IDLE, GRANTED)
//   - DEFAULT_QTY_OF_MASTERS / DEFAULT_QTY_OF_DEVICES : default fabric sizes
//   - MAX_MASTERS      : widest master vector the helpers below can describe
//   - onehot_from_idx  : index -> one-hot vector (MAX_MASTERS bits wide;
//                        callers cast it down to their own master count)
// ----------------------------------------------------------------------------
package interconnect_pkg;

    localparam int DEFAULT_QTY_OF_MASTERS = 4;
    localparam int DEFAULT_QTY_OF_DEVICES = 4;
    localparam int MAX_MASTERS            = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    function automatic logic [MAX_MASTERS-1:0] onehot_from_idx(input int unsigned idx);
        logic [MAX_MASTERS-1:0] one;
        one = {{(MAX_MASTERS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin search. Starting at `pointer` and moving upward,
// wrapping from QTY_OF_MASTERS-1 back to 0, the first request bit that is not
// masked by `exclude` wins.
// Ports:
//   request  in  [QTY_OF_MASTERS-1:0]  candidate request bits
//   pointer  in  [IDX_W-1:0]           highest-priority position this cycle
//   exclude  in  [QTY_OF_MASTERS-1:0]  bits that may not win
//   winner   out [IDX_W-1:0]           index of the winning master (0 if none)
//   found    out                       a winner exists
// ----------------------------------------------------------------------------
module rr_priority_picker
    import interconnect_pkg::*;
#(
    parameter int QTY_OF_MASTERS = DEFAULT_QTY_OF_MASTERS,
    parameter int IDX_W          = $clog2(QTY_OF_MASTERS)
) (
    input  logic [QTY_OF_MASTERS-1:0] request,
    input  logic [IDX_W-1:0]          pointer,
    input  logic [QTY_OF_MASTERS-1:0] exclude,
    output logic [IDX_W-1:0]          winner,
    output logic                      found
);

    logic [QTY_OF_MASTERS-1:0] eligible;
    logic [IDX_W-1:0]          scan;

    always_comb begin
        eligible = request & ~exclude;
        winner   = '0;
        found    = 1'b0;
        scan     = pointer;
        for (int k = 0; k < QTY_OF_MASTERS; k++) begin
            if (!found && eligible[scan]) begin
                found  = 1'b1;
                winner = scan;
            end
            // Explicit wrap at the last master so non-power-of-two counts
            // never visit an index that has no master behind it.
            if (scan == IDX_W'(QTY_OF_MASTERS - 1)) begin
                scan = '0;
            end else begin
                scan = scan + 1'b1;
            end
        end
    end

endmodule

// File: rtl/slave_rr_arbiter.sv
// ----------------------------------------------------------------------------
// slave_rr_arbiter
// Per-slave round-robin arbiter. Grants one master at a time, holds the grant
// until the slave acknowledges or the holder withdraws its request, then
// rotates priority to the master after the holder. A waiting master is
// granted at the same edge as the release (no bubble cycle).
// Ports:
//   clk                     in   clock, rising edge
//   rst_n                   in   synchronous active-low reset
//   request_from_listeners  in   [QTY_OF_MASTERS-1:0] per-master request level
//   slave_ack               in   one-cycle completion pulse from the slave
//   grant                   out  [QTY_OF_MASTERS-1:0] registered one-hot grant
//   grant_idx               out  [IDX_W-1:0] registered index of the holder
//   busy                    out  registered, high while a grant is active
// QTY_OF_MASTERS must lie in 2..MAX_MASTERS.
// ----------------------------------------------------------------------------
module slave_rr_arbiter
    import interconnect_pkg::*;
#(
    parameter int QTY_OF_MASTERS = DEFAULT_QTY_OF_MASTERS,
    parameter int IDX_W          = $clog2(QTY_OF_MASTERS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [QTY_OF_MASTERS-1:0] request_from_listeners,
    input  logic                      slave_ack,
    output logic [QTY_OF_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy
);

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [QTY_OF_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;
    logic                      busy_q, busy_d;

    logic                      release_now;
    logic [IDX_W-1:0]          ptr_after;
    logic [IDX_W-1:0]          pick_ptr;
    logic [QTY_OF_MASTERS-1:0] pick_excl;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_found;

    // Picker inputs. On a release the search already starts after the holder
    // and skips it, so the handover grant can be registered in this cycle.
    always_comb begin
        release_now = (state_q == GRANTED) &&
                      (slave_ack || !request_from_listeners[grant_idx_q]);
        ptr_after   = (grant_idx_q == IDX_W'(QTY_OF_MASTERS - 1)) ? '0
                                                                  : grant_idx_q + 1'b1;
        pick_ptr    = ptr_q;
        pick_excl   = '0;
        if (release_now) begin
            pick_ptr  = ptr_after;
            pick_excl = QTY_OF_MASTERS'(onehot_from_idx(32'(grant_idx_q)));
        end
    end

    rr_priority_picker #(
        .QTY_OF_MASTERS(QTY_OF_MASTERS),
        .IDX_W         (IDX_W)
    ) u_picker (
        .request(request_from_listeners),
        .pointer(pick_ptr),
        .exclude(pick_excl),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                // slave_ack is meaningless here and the pointer stays put.
                if (pick_found) begin
                    state_d     = GRANTED;
                    grant_d     = QTY_OF_MASTERS'(onehot_from_idx(32'(pick_idx)));
                    grant_idx_d = pick_idx;
                    busy_d      = 1'b1;
                end
            end
            GRANTED: begin
                if (release_now) begin
                    ptr_d = ptr_after;
                    if (pick_found) begin
                        grant_d     = QTY_OF_MASTERS'(onehot_from_idx(32'(pick_idx)));
                        grant_idx_d = pick_idx;
                    end else begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        grant_idx_d = '0;
                        busy_d      = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;

endmodule
